dmem_arb: RTL and testbench

Arbiter that shares the single data read port of the memory controller between the demand load path and the prefetcher. Demand loads issue immediately when credit allows. Prefetches are buffered in a small queue and issued only into spare slots, with an anti-starvation override. The controller returns data in issue order, so an in-order tag FIFO routes each response back to the requester that issued it.

---
 rtl/dmem_arb.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb.sv
// Shares the memory controller read port between demand loads and a queued prefetcher.
// In-order tag FIFO steers each response back to the requester that issued it.
module dmem_arb #(
    parameter int OUT_LOG = 3,
    parameter int PF_QLOG = 2,
    parameter int STARVE  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_re,
    input  logic [15:0]        ld_raddr,
    output logic               ld_stall,
    input  logic               pf_re,
    input  logic [15:0]        pf_raddr,
    output logic               pf_drop,
    output logic               mem_re,
    output logic [15:0]        mem_raddr,
    input  logic               mem_ready,
    input  logic [15:0]        mem_rdata,
    input  logic [15:0]        mem_raddr_in,
    output logic               ld_ready,
    output logic [15:0]        ld_addr,
    output logic [15:0]        ld_data,
    output logic               pf_ready,
    output logic [15:0]        pf_addr,
    output logic [15:0]        pf_data,
    output logic [OUT_LOG:0]   outstanding,
    output logic               err
);
    localparam int PF_DEPTH  = 1 << PF_QLOG;
    localparam int MAX_OUT_N = 1 << OUT_LOG;
    localparam int AGE_W     = $clog2(STARVE + 1);
    localparam logic [OUT_LOG:0] MAX_OUT    = {1'b1, {OUT_LOG{1'b0}}};
    localparam logic [OUT_LOG:0] MAX_OUT_M1 = {1'b0, {OUT_LOG{1'b1}}};
    localparam logic [PF_QLOG:0] PF_FULL    = {1'b1, {PF_QLOG{1'b0}}};
    localparam logic [AGE_W-1:0] STARVE_C   = AGE_W'(STARVE);

    logic [15:0]          pfq_mem_q [PF_DEPTH];
    logic [15:0]          pfq_mem_d [PF_DEPTH];
    logic [PF_QLOG-1:0]   pfq_wr_q, pfq_wr_d, pfq_rd_q, pfq_rd_d;
    logic [PF_QLOG:0]     pfq_cnt_q, pfq_cnt_d;
    logic [AGE_W-1:0]     age_q, age_d;
    logic [MAX_OUT_N-1:0] tag_mem_q, tag_mem_d;
    logic [OUT_LOG-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [OUT_LOG:0]     out_cnt_q, out_cnt_d;
    logic                 mem_re_q, mem_re_d;
    logic [15:0]          mem_raddr_q, mem_raddr_d;
    logic                 ld_ready_q, ld_ready_d, pf_ready_q, pf_ready_d;
    logic [15:0]          ld_addr_q, ld_addr_d, ld_data_q, ld_data_d;
    logic [15:0]          pf_addr_q, pf_addr_d, pf_data_q, pf_data_d;
    logic                 pf_drop_q, pf_drop_d, err_q, err_d;

    logic credit_ok_s, pf_avail_s, force_pf_s, dem_issue_s, pf_issue_s, issue_s;
    logic pf_full_s, pf_push_s, resp_valid_s, resp_tag_s, tag_empty_s;

    // Issue arbitration; credit is judged on the registered count only.
    always_comb begin
        credit_ok_s = (out_cnt_q < MAX_OUT);
        pf_avail_s  = (pfq_cnt_q != {(PF_QLOG+1){1'b0}});
        force_pf_s  = pf_avail_s && (age_q >= STARVE_C) && credit_ok_s;
        dem_issue_s = 1'b0;
        pf_issue_s  = 1'b0;
        if (force_pf_s) begin
            pf_issue_s = 1'b1;
        end else if (ld_re && credit_ok_s) begin
            dem_issue_s = 1'b1;
        end else if (pf_avail_s && (out_cnt_q < MAX_OUT_M1)) begin
            pf_issue_s = 1'b1;
        end else begin
            pf_issue_s = 1'b0;
        end
        issue_s      = dem_issue_s || pf_issue_s;
        pf_full_s    = (pfq_cnt_q == PF_FULL);
        pf_push_s    = pf_re && (!pf_full_s || pf_issue_s);
        tag_empty_s  = (out_cnt_q == {(OUT_LOG+1){1'b0}});
        resp_valid_s = mem_ready && !tag_empty_s;
        resp_tag_s   = tag_mem_q[tag_rd_q];
    end

    assign ld_stall = ld_re && !dem_issue_s;

    // Prefetch queue, head age and tag FIFO bookkeeping.
    always_comb begin
        pfq_mem_d = pfq_mem_q;
        if (pf_push_s) begin
            pfq_mem_d[pfq_wr_q] = pf_raddr;
        end else begin
            pfq_mem_d = pfq_mem_q;
        end
        pfq_wr_d = pf_push_s  ? pfq_wr_q + PF_QLOG'(1) : pfq_wr_q;
        pfq_rd_d = pf_issue_s ? pfq_rd_q + PF_QLOG'(1) : pfq_rd_q;
        case ({pf_push_s, pf_issue_s})
            2'b10:   pfq_cnt_d = pfq_cnt_q + (PF_QLOG+1)'(1);
            2'b01:   pfq_cnt_d = pfq_cnt_q - (PF_QLOG+1)'(1);
            default: pfq_cnt_d = pfq_cnt_q;
        endcase
        if (pf_issue_s || !pf_avail_s) begin
            age_d = {AGE_W{1'b0}};
        end else if (age_q < STARVE_C) begin
            age_d = age_q + AGE_W'(1);
        end else begin
            age_d = age_q;
        end
        tag_mem_d = tag_mem_q;
        if (issue_s) begin
            tag_mem_d[tag_wr_q] = pf_issue_s;
        end else begin
            tag_mem_d = tag_mem_q;
        end
        tag_wr_d = issue_s      ? tag_wr_q + OUT_LOG'(1) : tag_wr_q;
        tag_rd_d = resp_valid_s ? tag_rd_q + OUT_LOG'(1) : tag_rd_q;
        case ({issue_s, resp_valid_s})
            2'b10:   out_cnt_d = out_cnt_q + (OUT_LOG+1)'(1);
            2'b01:   out_cnt_d = out_cnt_q - (OUT_LOG+1)'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Registered issue port, response routing and status flags.
    always_comb begin
        mem_re_d    = issue_s;
        mem_raddr_d = dem_issue_s ? ld_raddr :
                      (pf_issue_s ? pfq_mem_q[pfq_rd_q] : mem_raddr_q);
        ld_ready_d  = resp_valid_s && !resp_tag_s;
        pf_ready_d  = resp_valid_s && resp_tag_s;
        ld_addr_d   = ld_ready_d ? mem_raddr_in : ld_addr_q;
        ld_data_d   = ld_ready_d ? mem_rdata    : ld_data_q;
        pf_addr_d   = pf_ready_d ? mem_raddr_in : pf_addr_q;
        pf_data_d   = pf_ready_d ? mem_rdata    : pf_data_q;
        pf_drop_d   = pf_re && pf_full_s && !pf_issue_s;
        err_d       = err_q || (mem_ready && tag_empty_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PF_DEPTH; i++) pfq_mem_q[i] <= 16'h0000;
            pfq_wr_q    <= {PF_QLOG{1'b0}};
            pfq_rd_q    <= {PF_QLOG{1'b0}};
            pfq_cnt_q   <= {(PF_QLOG+1){1'b0}};
            age_q       <= {AGE_W{1'b0}};
            tag_mem_q   <= {MAX_OUT_N{1'b0}};
            tag_wr_q    <= {OUT_LOG{1'b0}};
            tag_rd_q    <= {OUT_LOG{1'b0}};
            out_cnt_q   <= {(OUT_LOG+1){1'b0}};
            mem_re_q    <= 1'b0;
            mem_raddr_q <= 16'h0000;
            ld_ready_q  <= 1'b0;
            ld_addr_q   <= 16'h0000;
            ld_data_q   <= 16'h0000;
            pf_ready_q  <= 1'b0;
            pf_addr_q   <= 16'h0000;
            pf_data_q   <= 16'h0000;
            pf_drop_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pfq_mem_q   <= pfq_mem_d;
            pfq_wr_q    <= pfq_wr_d;
            pfq_rd_q    <= pfq_rd_d;
            pfq_cnt_q   <= pfq_cnt_d;
            age_q       <= age_d;
            tag_mem_q   <= tag_mem_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            out_cnt_q   <= out_cnt_d;
            mem_re_q    <= mem_re_d;
            mem_raddr_q <= mem_raddr_d;
            ld_ready_q  <= ld_ready_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            pf_ready_q  <= pf_ready_d;
            pf_addr_q   <= pf_addr_d;
            pf_data_q   <= pf_data_d;
            pf_drop_q   <= pf_drop_d;
            err_q       <= err_d;
        end
    end

    assign mem_re      = mem_re_q;
    assign mem_raddr   = mem_raddr_q;
    assign ld_ready    = ld_ready_q;
    assign ld_addr     = ld_addr_q;
    assign ld_data     = ld_data_q;
    assign pf_ready    = pf_ready_q;
    assign pf_addr     = pf_addr_q;
    assign pf_data     = pf_data_q;
    assign pf_drop     = pf_drop_q;
    assign err         = err_q;
    assign outstanding = out_cnt_q;
endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: inputs change on the falling edge, outputs checked there too.
module tb_dmem_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_re = 1'b0, pf_re = 1'b0, mem_ready = 1'b0;
    logic [15:0] ld_raddr = 16'h0000, pf_raddr = 16'h0000;
    logic [15:0] mem_rdata = 16'h0000, mem_raddr_in = 16'h0000;
    logic        ld_stall, pf_drop, mem_re, ld_ready, pf_ready, err;
    logic [15:0] mem_raddr, ld_addr, ld_data, pf_addr, pf_data;
    logic [3:0]  outstanding;
    int          n_cmp = 0;
    int          n_mis = 0;

    dmem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .ld_re(ld_re), .ld_raddr(ld_raddr), .ld_stall(ld_stall),
        .pf_re(pf_re), .pf_raddr(pf_raddr), .pf_drop(pf_drop),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_raddr_in(mem_raddr_in),
        .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .pf_ready(pf_ready), .pf_addr(pf_addr), .pf_data(pf_data),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
        check({tag, "_mem_raddr"}, {16'd0, mem_raddr}, 32'd0);
        check({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd0);
        check({tag, "_ld_addr"}, {16'd0, ld_addr}, 32'd0);
        check({tag, "_ld_data"}, {16'd0, ld_data}, 32'd0);
        check({tag, "_pf_ready"}, {31'd0, pf_ready}, 32'd0);
        check({tag, "_pf_addr"}, {16'd0, pf_addr}, 32'd0);
        check({tag, "_pf_data"}, {16'd0, pf_data}, 32'd0);
        check({tag, "_pf_drop"}, {31'd0, pf_drop}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_outstanding"}, {28'd0, outstanding}, 32'd0);
    endtask

    initial begin
        #1;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Demand credit limit: eight issue, the ninth stalls until one response.
        for (int i = 0; i < 8; i++) begin
            ld_re = 1'b1;
            ld_raddr = 16'h1000 + 16'(i);
            #1 check("cr_stall", {31'd0, ld_stall}, 32'd0);
            @(negedge clk);
            check("cr_mem_re", {31'd0, mem_re}, 32'd1);
            check("cr_raddr", {16'd0, mem_raddr}, 32'h1000 + i);
            check("cr_out", {28'd0, outstanding}, i + 1);
        end
        ld_raddr = 16'h1008;
        #1 check("cr9_stall", {31'd0, ld_stall}, 32'd1);
        @(negedge clk);
        check("cr9_no_issue", {31'd0, mem_re}, 32'd0);
        check("cr9_out", {28'd0, outstanding}, 32'd8);
        mem_ready = 1'b1; mem_rdata = 16'h1111; mem_raddr_in = 16'h1000;
        #1 check("cr9_stall_resp", {31'd0, ld_stall}, 32'd1);
        @(negedge clk);
        mem_ready = 1'b0;
        check("cr9_out_freed", {28'd0, outstanding}, 32'd7);
        check("cr9_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("cr9_ld_data", {16'd0, ld_data}, 32'h1111);
        check("cr9_ld_addr", {16'd0, ld_addr}, 32'h1000);
        #1 check("cr9_unstall", {31'd0, ld_stall}, 32'd0);
        @(negedge clk);
        ld_re = 1'b0;
        check("cr9_issue", {31'd0, mem_re}, 32'd1);
        check("cr9_raddr", {16'd0, mem_raddr}, 32'h1008);
        check("cr9_out8", {28'd0, outstanding}, 32'd8);
        check("cr9_ld_ready_pulse", {31'd0, ld_ready}, 32'd0);

        // Prefetch reserve: outstanding=7 keeps the queue waiting; fifth push is dropped.
        mem_ready = 1'b1; mem_rdata = 16'h2222; mem_raddr_in = 16'h1001;
        pf_re = 1'b1; pf_raddr = 16'h0100;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rs_out7", {28'd0, outstanding}, 32'd7);
        check("rs_ld_data", {16'd0, ld_data}, 32'h2222);
        for (int i = 1; i < 4; i++) begin
            pf_raddr = 16'h0100 + 16'(i);
            @(negedge clk);
            check("rs_no_pf_issue", {31'd0, mem_re}, 32'd0);
            check("rs_no_drop", {31'd0, pf_drop}, 32'd0);
        end
        pf_raddr = 16'h0200;
        @(negedge clk);
        pf_re = 1'b0;
        check("rs_drop", {31'd0, pf_drop}, 32'd1);
        check("rs_no_issue", {31'd0, mem_re}, 32'd0);
        check("rs_out", {28'd0, outstanding}, 32'd7);
        @(negedge clk);
        check("rs_drop_pulse", {31'd0, pf_drop}, 32'd0);
        // Drain: each response frees a slot below the reserve, queue comes out in order.
        mem_ready = 1'b1; mem_raddr_in = 16'h1002;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("dr_wait", {31'd0, mem_re}, 32'd0);
            end else begin
                check("dr_issue", {31'd0, mem_re}, 32'd1);
                check("dr_raddr", {16'd0, mem_raddr}, 32'h0100 + j - 1);
            end
            if (j == 3) mem_ready = 1'b0;
        end
        @(negedge clk);
        check("dr_issue4", {31'd0, mem_re}, 32'd1);
        check("dr_raddr4", {16'd0, mem_raddr}, 32'h0103);
        check("dr_out", {28'd0, outstanding}, 32'd7);
        @(negedge clk);
        check("dr_dropped_gone", {31'd0, mem_re}, 32'd0);

        // Reset with traffic in flight.
        ld_re = 1'b1; ld_raddr = 16'h0900;
        @(negedge clk);
        check("rst_pre_issue", {31'd0, mem_re}, 32'd1);
        check("rst_pre_out", {28'd0, outstanding}, 32'd8);
        rst_n = 1'b0; ld_re = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        ld_re = 1'b1; ld_raddr = 16'h0040;
        #1 check("post_rst_stall", {31'd0, ld_stall}, 32'd0);
        @(negedge clk);
        ld_re = 1'b0;
        check("post_rst_issue", {31'd0, mem_re}, 32'd1);
        check("post_rst_raddr", {16'd0, mem_raddr}, 32'h0040);
        check("post_rst_out", {28'd0, outstanding}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 16'h4040; mem_raddr_in = 16'h0040;
        @(negedge clk);
        mem_ready = 1'b0;
        check("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("post_rst_ld_data", {16'd0, ld_data}, 32'h4040);
        check("post_rst_out0", {28'd0, outstanding}, 32'd0);

        // Routing order: demand, prefetch, demand.
        ld_re = 1'b1; ld_raddr = 16'h0010; pf_re = 1'b1; pf_raddr = 16'h0020;
        @(negedge clk);
        ld_re = 1'b0; pf_re = 1'b0;
        check("ro_raddr0", {16'd0, mem_raddr}, 32'h0010);
        @(negedge clk);
        check("ro_pf_issue", {31'd0, mem_re}, 32'd1);
        check("ro_raddr1", {16'd0, mem_raddr}, 32'h0020);
        ld_re = 1'b1; ld_raddr = 16'h0030;
        @(negedge clk);
        ld_re = 1'b0;
        check("ro_raddr2", {16'd0, mem_raddr}, 32'h0030);
        check("ro_out3", {28'd0, outstanding}, 32'd3);
        mem_ready = 1'b1; mem_rdata = 16'hAAAA; mem_raddr_in = 16'h0010;
        @(negedge clk);
        check("ro_r0_ld", {31'd0, ld_ready}, 32'd1);
        check("ro_r0_pf", {31'd0, pf_ready}, 32'd0);
        check("ro_r0_data", {16'd0, ld_data}, 32'hAAAA);
        mem_rdata = 16'hBBBB; mem_raddr_in = 16'h0020;
        @(negedge clk);
        check("ro_r1_ld", {31'd0, ld_ready}, 32'd0);
        check("ro_r1_pf", {31'd0, pf_ready}, 32'd1);
        check("ro_r1_data", {16'd0, pf_data}, 32'hBBBB);
        check("ro_r1_addr", {16'd0, pf_addr}, 32'h0020);
        mem_rdata = 16'hCCCC; mem_raddr_in = 16'h0030;
        @(negedge clk);
        mem_ready = 1'b0;
        check("ro_r2_ld", {31'd0, ld_ready}, 32'd1);
        check("ro_r2_pf", {31'd0, pf_ready}, 32'd0);
        check("ro_r2_data", {16'd0, ld_data}, 32'hCCCC);
        check("ro_r2_addr", {16'd0, ld_addr}, 32'h0030);
        @(negedge clk);
        check("ro_ld_pulse", {31'd0, ld_ready}, 32'd0);
        check("ro_out0", {28'd0, outstanding}, 32'd0);

        // Starvation: continuous demand, prefetch pushed alongside the first one.
        ld_re = 1'b1; ld_raddr = 16'h0500; pf_re = 1'b1; pf_raddr = 16'h0300;
        mem_rdata = 16'h5555; mem_raddr_in = 16'h0500;
        #1 check("st_stall0", {31'd0, ld_stall}, 32'd0);
        @(negedge clk);
        pf_re = 1'b0; mem_ready = 1'b1;
        for (int k = 1; k < 20; k++) begin
            #1 check("st_stall", {31'd0, ld_stall}, (k == 17) ? 32'd1 : 32'd0);
            @(negedge clk);
            check("st_issue", {31'd0, mem_re}, 32'd1);
            check("st_raddr", {16'd0, mem_raddr}, (k == 17) ? 32'h0300 : 32'h0500);
            check("st_pf_ready", {31'd0, pf_ready}, (k == 18) ? 32'd1 : 32'd0);
        end
        ld_re = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        check("st_out0", {28'd0, outstanding}, 32'd0);
        check("st_no_err", {31'd0, err}, 32'd0);

        // Error: response with nothing outstanding.
        mem_ready = 1'b1; mem_rdata = 16'hDEAD; mem_raddr_in = 16'h0BAD;
        @(negedge clk);
        mem_ready = 1'b0;
        check("er_set", {31'd0, err}, 32'd1);
        check("er_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("er_pf_ready", {31'd0, pf_ready}, 32'd0);
        check("er_out", {28'd0, outstanding}, 32'd0);
        repeat (3) @(negedge clk);
        check("er_sticky", {31'd0, err}, 32'd1);
        rst_n = 1'b0;
        #1 check("er_reset", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
